simmem_bank_sched: RTL and testbench

Single-bank access scheduler for the simulated memory controller. Arbitrates between the write-address and read-address request streams, models the row-buffer state of one DRAM bank, and holds the bank busy for the access cost. Costs are row hit, row closed or row conflict. On completion it pulses the internal identifier (iid) back, so the response banks know when to release the burst. It sits between the AW/AR request splitters and the `wrsp`/`rdata` response banks.

---
 rtl/simmem_bank_sched.sv | 121 ++++++++++++
 tb/tb_simmem_bank_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/simmem_bank_sched.sv
// Single-bank DRAM access scheduler: round-robin W/R arbitration, open-page row
// buffer model and a busy down-counter that pulses the finished iid back.
package simmem_pkg;
  localparam int AxAddrWidth    = 19;
  localparam int RowBufLenW     = 10;
  localparam int WRspBankAddrW  = 4;
  localparam int RDataBankAddrW = 4;
  localparam int RowHitCost     = 4;
  localparam int PrechargeCost  = 2;
  localparam int ActivationCost = 1;

  typedef enum logic {
    WRSP_BANK  = 1'b0,
    RDATA_BANK = 1'b1
  } rsp_bank_type_e;
endpackage

// state | meaning
// IDLE  | no access in service, bank free
// SERVE | access being timed; cnt_q counts cost-1 down to 0, done fires at 0
module simmem_bank_sched
  import simmem_pkg::*;
#(
  parameter int RowHitCost     = simmem_pkg::RowHitCost,
  parameter int PrechargeCost  = simmem_pkg::PrechargeCost,
  parameter int ActivationCost = simmem_pkg::ActivationCost,
  parameter int CntW           = $clog2(RowHitCost + PrechargeCost + ActivationCost)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [AxAddrWidth-1:0]    w_addr_i,
  input  logic [WRspBankAddrW-1:0]  w_iid_i,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [AxAddrWidth-1:0]    r_addr_i,
  input  logic [RDataBankAddrW-1:0] r_iid_i,
  output logic                      w_done_o,
  output logic [WRspBankAddrW-1:0]  w_done_iid_o,
  output logic                      r_done_o,
  output logic [RDataBankAddrW-1:0] r_done_iid_o,
  output logic                      busy_o
);
  localparam int RowIdW = AxAddrWidth - RowBufLenW;
  localparam int IidW   = (WRspBankAddrW > RDataBankAddrW) ? WRspBankAddrW : RDataBankAddrW;
  localparam logic [CntW:0] HitC = (CntW+1)'(RowHitCost);
  localparam logic [CntW:0] ActC = (CntW+1)'(ActivationCost);
  localparam logic [CntW:0] PreC = (CntW+1)'(PrechargeCost);

  typedef enum logic {IDLE, SERVE} state_e;

  state_e              state_q;
  logic                open_q;
  logic [RowIdW-1:0]   row_q;
  logic [CntW-1:0]     cnt_q;
  rsp_bank_type_e      kind_q;
  logic [IidW-1:0]     iid_q;
  rsp_bank_type_e      prio_q;

  logic                serve_end, free, grant_w, grant_r, hs;
  logic [RowIdW-1:0]   w_row, r_row, g_row;
  logic [CntW:0]       cost, cost_m1;
  logic [CntW-1:0]     cnt_load;

  assign w_row = w_addr_i[AxAddrWidth-1:RowBufLenW];
  assign r_row = r_addr_i[AxAddrWidth-1:RowBufLenW];

  assign serve_end = (state_q == SERVE) && (cnt_q == '0);
  assign free      = (state_q == IDLE) || serve_end;

  assign grant_w = free && w_valid_i && (!r_valid_i || prio_q == WRSP_BANK);
  assign grant_r = free && r_valid_i && (!w_valid_i || prio_q == RDATA_BANK);
  assign hs      = grant_w || grant_r;
  assign g_row   = grant_w ? w_row : r_row;

  assign w_ready_o = grant_w;
  assign r_ready_o = grant_r;

  always_comb begin
    cost = HitC;
    if (!open_q)             cost = ActC + HitC;
    else if (g_row != row_q) cost = PreC + ActC + HitC;
  end

  // cost is formed one bit wider, then the counter keeps only cost-1
  assign cost_m1  = cost - (CntW+1)'(1);
  assign cnt_load = cost_m1[CntW-1:0];

  assign w_done_o     = serve_end && (kind_q == WRSP_BANK);
  assign r_done_o     = serve_end && (kind_q == RDATA_BANK);
  assign w_done_iid_o = w_done_o ? iid_q[WRspBankAddrW-1:0] : '0;
  assign r_done_iid_o = r_done_o ? iid_q[RDataBankAddrW-1:0] : '0;
  assign busy_o       = (state_q == SERVE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      open_q  <= 1'b0;
      row_q   <= '0;
      cnt_q   <= '0;
      kind_q  <= WRSP_BANK;
      iid_q   <= '0;
      prio_q  <= WRSP_BANK;
    end else if (hs) begin
      state_q <= SERVE;
      open_q  <= 1'b1;
      row_q   <= g_row;
      cnt_q   <= cnt_load;
      kind_q  <= grant_w ? WRSP_BANK : RDATA_BANK;
      iid_q   <= grant_w ? IidW'(w_iid_i) : IidW'(r_iid_i);
      prio_q  <= grant_w ? RDATA_BANK : WRSP_BANK;
    end else if (state_q == SERVE) begin
      if (cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
      else             state_q <= IDLE;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{w_addr_i[RowBufLenW-1:0], r_addr_i[RowBufLenW-1:0], cost_m1[CntW]};
endmodule

// File: tb/tb_simmem_bank_sched.sv
// Scoreboard bench for simmem_bank_sched: a cost/row/round-robin reference model
// predicts grants and done pulses; a separate monitor pops and compares done events.
module tb_simmem_bank_sched;
  localparam int HIT = 4, PRE = 2, ACT = 1;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        w_valid_i = 1'b0, r_valid_i = 1'b0;
  logic [18:0] w_addr_i = '0, r_addr_i = '0;
  logic [3:0]  w_iid_i = '0, r_iid_i = '0;
  logic        w_ready_o, r_ready_o, w_done_o, r_done_o, busy_o;
  logic [3:0]  w_done_iid_o, r_done_iid_o;

  simmem_bank_sched dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_addr_i(w_addr_i), .w_iid_i(w_iid_i),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_addr_i(r_addr_i), .r_iid_i(r_iid_i),
    .w_done_o(w_done_o), .w_done_iid_o(w_done_iid_o),
    .r_done_o(r_done_o), .r_done_iid_o(r_done_iid_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct {
    int       due;
    bit       is_r;
    bit [3:0] iid;
  } exp_t;
  exp_t exp_q[$];

  // reference model state
  bit  m_open = 0, m_serving = 0, m_prio_r = 0;
  int  m_row = 0, m_end = 0;
  bit  hs_w, hs_r, dut_gw, dut_gr;
  int  hs_cyc;
  int  last_w_done = -1, last_r_done = -1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_cycle();
    bit free, gw, gr;
    int row, cost;
    free = !m_serving || (cyc == m_end);
    gw = free && w_valid_i && (!r_valid_i || !m_prio_r);
    gr = free && r_valid_i && (!w_valid_i || m_prio_r);
    dut_gw = w_ready_o && w_valid_i;
    dut_gr = r_ready_o && r_valid_i;
    chk("w_ready", int'(w_ready_o), int'(gw));
    chk("r_ready", int'(r_ready_o), int'(gr));
    chk("busy", int'(busy_o), int'(m_serving));
    if (m_serving && cyc == m_end) m_serving = 0;
    hs_w = gw;
    hs_r = gr;
    if (gw || gr) begin
      row = gw ? int'(w_addr_i[18:10]) : int'(r_addr_i[18:10]);
      if (!m_open)          cost = ACT + HIT;
      else if (row == m_row) cost = HIT;
      else                   cost = PRE + ACT + HIT;
      exp_q.push_back('{due: cyc + cost, is_r: gr, iid: gw ? w_iid_i : r_iid_i});
      m_open = 1;
      m_row = row;
      m_prio_r = gw;
      m_serving = 1;
      m_end = cyc + cost;
      hs_cyc = cyc;
    end
  endtask

  // inputs change 1 time unit after posedge; model and DUT compared at negedge
  task automatic step(input bit wv, input logic [18:0] wa, input logic [3:0] wi,
                      input bit rv, input logic [18:0] ra, input logic [3:0] ri);
    w_valid_i = wv; w_addr_i = wa; w_iid_i = wi;
    r_valid_i = rv; r_addr_i = ra; r_iid_i = ri;
    @(negedge clk_i);
    model_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    w_valid_i = 0; r_valid_i = 0;
    exp_q.delete();
    m_open = 0; m_serving = 0; m_prio_r = 0; m_row = 0;
    @(negedge clk_i);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(w_done_o | r_done_o), 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic issue(input bit is_w, input logic [18:0] a, input logic [3:0] id, output int t);
    int n = 0;
    hs_w = 0; hs_r = 0;
    do begin
      step(is_w, a, id, !is_w, a, id);
      n++;
    end while (!(hs_w || hs_r) && n < 50);
    if (!(hs_w || hs_r)) chk("issue_timeout", 0, 1);
    t = hs_cyc;
  endtask

  task automatic wait_done(input bit is_r, input int t_hs, output int td);
    int n = 0;
    while ((is_r ? last_r_done : last_w_done) <= t_hs && n < 30) begin
      idle(1);
      n++;
    end
    td = is_r ? last_r_done : last_w_done;
    if (td <= t_hs) chk("done_timeout", td, t_hs + 1);
  endtask

  // monitor: every done pulse must match the oldest predicted completion
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      if (w_done_o || r_done_o) begin
        chk("single_done", int'(w_done_o & r_done_o), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("done_kind", int'(r_done_o), int'(e.is_r));
          chk("done_iid", r_done_o ? int'(r_done_iid_o) : int'(w_done_iid_o), int'(e.iid));
        end
        if (w_done_o) last_w_done = cyc;
        if (r_done_o) last_r_done = cyc;
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_done", cyc, e.due);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, tr, tw, td, reqs;
    int kinds[$];
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_w_ready", int'(w_ready_o), 0);
    chk("rst_r_ready", int'(r_ready_o), 0);
    chk("rst_busy0", int'(busy_o), 0);
    chk("rst_iids", int'(w_done_iid_o) + int'(r_done_iid_o), 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // closed row, then back-to-back row hit, then conflict and hit
    issue(1, 19'h00400, 4'd1, t0);
    idle(4);
    step(0, '0, '0, 1, 19'h007FC, 4'd0);
    chk("b2b_accept", int'(dut_gr), 1);
    tr = hs_cyc;
    wait_done(0, t0, td);
    chk("closed_cost", td - t0, 5);
    wait_done(1, tr, td);
    chk("hit_after_b2b", td - t0, 9);
    issue(1, 19'h00800, 4'd7, tw);
    wait_done(0, tw, td);
    chk("conflict_cost", td - tw, 7);
    issue(1, 19'h00800, 4'd3, tw);
    wait_done(0, tw, td);
    chk("hit_cost", td - tw, 4);

    // both sides valid continuously: grants must alternate
    do_reset();
    for (int i = 0; i < 24; i++) begin
      step(1, 19'h00010, 4'(i), 1, 19'h00020, 4'(i + 8));
      if (dut_gw) kinds.push_back(0);
      if (dut_gr) kinds.push_back(1);
    end
    chk("alt_grants", (kinds.size() >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4 && i < kinds.size(); i++) chk("alt_order", kinds[i], i % 2);
    idle(10);

    // reset two cycles into service aborts the access and closes the row
    issue(1, 19'h01000, 4'd5, tw);
    idle(2);
    do_reset();
    idle(10);
    chk("abort_no_done", (last_w_done > tw) ? 1 : 0, 0);
    issue(1, 19'h01000, 4'd6, tw);
    wait_done(0, tw, td);
    chk("closed_after_reset", td - tw, 5);

    // random traffic over a few rows for plenty of hits and conflicts
    reqs = 0;
    for (int n = 0; n < 30000 && reqs < 1000; n++) begin
      step($urandom_range(0, 1), 19'(($urandom_range(0, 3) << 10) | $urandom_range(0, 1023)),
           4'($urandom_range(0, 15)),
           $urandom_range(0, 1), 19'(($urandom_range(0, 3) << 10) | $urandom_range(0, 1023)),
           4'($urandom_range(0, 15)));
      if (hs_w || hs_r) reqs++;
    end
    chk("random_reqs", (reqs >= 1000) ? 1 : 0, 1);
    idle(12);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
